// File: rtl/gray_ptr_receiver_if.sv
// Signal bundle for the Gray-pointer receiver: remote Gray pointer in, decoded pointer and status out.
// There is no valid/ready handshake. grayPtrIn is free-running and asynchronous to clk; every other signal is clk-synchronous.
interface gray_ptr_receiver_if #(
  parameter int N = 4
);
  logic [N-1:0] grayPtrIn;
  logic [N-1:0] localBinPtr;
  logic         errClr;
  logic [N-1:0] binPtrOut;
  logic         ptrAdvance;
  logic [N-1:0] level;
  logic         empty;
  logic         grayErr;
  logic         levelErr;

  modport master (
    output grayPtrIn,
    output localBinPtr,
    output errClr,
    input  binPtrOut,
    input  ptrAdvance,
    input  level,
    input  empty,
    input  grayErr,
    input  levelErr
  );

  modport slave (
    input  grayPtrIn,
    input  localBinPtr,
    input  errClr,
    output binPtrOut,
    output ptrAdvance,
    output level,
    output empty,
    output grayErr,
    output levelErr
  );
endinterface

// File: rtl/gray_ptr_receiver.sv
// Read-side receiver for an async FIFO write pointer: synchronize, Gray-decode, compute level and empty, flag crossing errors.
// Optional macro GRAY_RX_PIPE_EN adds one register stage between decode and binPtrOut.
module gray_ptr_receiver #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic                clk,
  input logic                rstN,
  gray_ptr_receiver_if.slave bus
);

  localparam logic [N-1:0] DEPTH = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] ONE   = {{(N-1){1'b0}}, 1'b1};

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("gray_ptr_receiver: SYNC_STAGES must be 2..4");
  end

  logic [SYNC_STAGES-1:0][N-1:0] sync_q;
  logic [SYNC_STAGES-1:0][N-1:0] sync_d;
  logic [N-1:0] gray_s;
  logic [N-1:0] prev_gray_q;
  logic [N-1:0] prev_gray_d;
  logic [N-1:0] gray_diff;
  logic         gray_changed;
  logic         gray_multi;
  logic [N-1:0] dec_bin;
  logic [N-1:0] bin_ptr_q;
  logic [N-1:0] bin_ptr_d;
  logic         ptr_adv_q;
  logic         ptr_adv_d;
  logic [N-1:0] level_c;
  logic         gray_err_q;
  logic         gray_err_d;
  logic         level_err_q;
  logic         level_err_d;

  function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
    logic [N-1:0] b;
    b = g;
    for (int i = N - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Pure flop chain: nothing combinational may sit between synchronizer stages.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], bus.grayPtrIn};
  end

  always_comb begin
    gray_s       = sync_q[SYNC_STAGES-1];
    prev_gray_d  = gray_s;
    gray_diff    = gray_s ^ prev_gray_q;
    gray_changed = |gray_diff;
    // x & (x-1) is nonzero exactly when more than one bit of x is set.
    gray_multi   = |(gray_diff & (gray_diff - ONE));
    dec_bin      = gray2bin(gray_s);
  end

`ifdef GRAY_RX_PIPE_EN
  logic [N-1:0] pipe_bin_q;
  logic [N-1:0] pipe_bin_d;
  logic         pipe_adv_q;
  logic         pipe_adv_d;

  // The change flag rides the same extra stage as the decoded value so they stay aligned.
  always_comb begin
    pipe_bin_d = dec_bin;
    pipe_adv_d = gray_changed;
    bin_ptr_d  = pipe_bin_q;
    ptr_adv_d  = pipe_adv_q;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      pipe_bin_q <= '0;
      pipe_adv_q <= 1'b0;
    end else begin
      pipe_bin_q <= pipe_bin_d;
      pipe_adv_q <= pipe_adv_d;
    end
  end
`else
  always_comb begin
    bin_ptr_d = dec_bin;
    ptr_adv_d = gray_changed;
  end
`endif

  // Sticky error flags: a new set on the same edge as errClr takes priority.
  always_comb begin
    level_c     = bin_ptr_q - bus.localBinPtr;
    gray_err_d  = gray_err_q;
    level_err_d = level_err_q;
    if (bus.errClr) begin
      gray_err_d  = 1'b0;
      level_err_d = 1'b0;
    end
    if (gray_multi) begin
      gray_err_d = 1'b1;
    end
    if (level_c > DEPTH) begin
      level_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sync_q      <= '0;
      prev_gray_q <= '0;
      bin_ptr_q   <= '0;
      ptr_adv_q   <= 1'b0;
      gray_err_q  <= 1'b0;
      level_err_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      prev_gray_q <= prev_gray_d;
      bin_ptr_q   <= bin_ptr_d;
      ptr_adv_q   <= ptr_adv_d;
      gray_err_q  <= gray_err_d;
      level_err_q <= level_err_d;
    end
  end

  assign bus.binPtrOut  = bin_ptr_q;
  assign bus.ptrAdvance = ptr_adv_q;
  assign bus.level      = level_c;
  assign bus.empty      = (bin_ptr_q == bus.localBinPtr);
  assign bus.grayErr    = gray_err_q;
  assign bus.levelErr   = level_err_q;

endmodule

// File: tb/tb_gray_ptr_receiver.sv
// Self-checking bench for gray_ptr_receiver: reset, Gray walk, level/wrap, violation, mid-run reset, random stream.
// Build with GRAY_RX_PIPE_EN defined to cover the extra decode stage.
module tb_gray_ptr_receiver;
  localparam int N  = 4;
  localparam int SS = 2;
  // Negedges from driving grayPtrIn until binPtrOut shows it.
`ifdef GRAY_RX_PIPE_EN
  localparam int LAT = SS + 2;
`else
  localparam int LAT = SS + 1;
`endif

  logic clk = 1'b0;
  logic rstN;
  int   total = 0;
  int   bad   = 0;
  logic [N:0] exp_q[$];

  always #5 clk = ~clk;

  gray_ptr_receiver_if #(.N(N)) bus ();

  gray_ptr_receiver #(.N(N), .SYNC_STAGES(SS)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  function automatic logic [N-1:0] bin2gray(input logic [N-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [N-1:0] model_bin(input logic [N-1:0] g);
    logic [N-1:0] b;
    b = '0;
    for (int i = 0; i < N; i++) b = b ^ (g >> i);
    return b;
  endfunction

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    bus.errClr = 1'b1;
    @(negedge clk);
    bus.errClr = 1'b0;
  endtask

  task automatic test_reset();
    rstN = 1'b1;
    bus.grayPtrIn   = '0;
    bus.localBinPtr = '0;
    bus.errClr      = 1'b0;
    #1 rstN = 1'b0;
    #1;
    total++; if (bus.binPtrOut !== 4'd0) begin bad++; $display("FAIL reset_bin: got %0h want 0", bus.binPtrOut); end
    total++; if (bus.ptrAdvance !== 1'b0) begin bad++; $display("FAIL reset_adv: got %0b want 0", bus.ptrAdvance); end
    total++; if (bus.grayErr !== 1'b0) begin bad++; $display("FAIL reset_grayerr: got %0b want 0", bus.grayErr); end
    total++; if (bus.levelErr !== 1'b0) begin bad++; $display("FAIL reset_levelerr: got %0b want 0", bus.levelErr); end
    total++; if (bus.level !== 4'd0) begin bad++; $display("FAIL reset_level: got %0h want 0", bus.level); end
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %0b want 1", bus.empty); end
    @(negedge clk);
    rstN = 1'b1;
    settle(LAT + 1);
  endtask

  task automatic test_gray_walk();
    logic [N-1:0] cur_gray;
    logic [N-1:0] g;
    logic [N:0]   e;
    cur_gray = bus.grayPtrIn;
    exp_q.delete();
    for (int c = 0; c < 17 + LAT + 1; c++) begin
      @(negedge clk);
      if (exp_q.size() == LAT) begin
        e = exp_q.pop_front();
        total++; if (bus.binPtrOut !== e[N-1:0]) begin bad++; $display("FAIL walk_bin[%0d]: got %0h want %0h", c, bus.binPtrOut, e[N-1:0]); end
        total++; if (bus.ptrAdvance !== e[N]) begin bad++; $display("FAIL walk_adv[%0d]: got %0b want %0b", c, bus.ptrAdvance, e[N]); end
        total++; if (bus.level !== e[N-1:0]) begin bad++; $display("FAIL walk_level[%0d]: got %0h want %0h", c, bus.level, e[N-1:0]); end
      end
      g = (c < 17) ? bin2gray(4'(c % 16)) : cur_gray;
      exp_q.push_back({(g != cur_gray), model_bin(g)});
      cur_gray = g;
      bus.grayPtrIn = g;
    end
    total++; if (bus.grayErr !== 1'b0) begin bad++; $display("FAIL walk_grayerr: got %0b want 0", bus.grayErr); end
    // The walk reaches level 15 with local pointer 0, which exceeds depth 8.
    total++; if (bus.levelErr !== 1'b1) begin bad++; $display("FAIL walk_levelerr: got %0b want 1", bus.levelErr); end
    pulse_clear();
    total++; if (bus.levelErr !== 1'b0) begin bad++; $display("FAIL walk_levelerr_clr: got %0b want 0", bus.levelErr); end
  endtask

  task automatic test_level_wrap();
    @(negedge clk);
    bus.grayPtrIn = 4'b1100;
    settle(LAT + 1);
    total++; if (bus.grayErr !== 1'b1) begin bad++; $display("FAIL wrap_jump_grayerr: got %0b want 1", bus.grayErr); end
    pulse_clear();
    total++; if (bus.binPtrOut !== 4'd8) begin bad++; $display("FAIL wrap_bin8: got %0h want 8", bus.binPtrOut); end
    total++; if (bus.level !== 4'd8) begin bad++; $display("FAIL wrap_level8: got %0h want 8", bus.level); end
    total++; if (bus.empty !== 1'b0) begin bad++; $display("FAIL wrap_empty0: got %0b want 0", bus.empty); end
    total++; if (bus.levelErr !== 1'b0) begin bad++; $display("FAIL wrap_levelerr8: got %0b want 0", bus.levelErr); end
    total++; if (bus.grayErr !== 1'b0) begin bad++; $display("FAIL wrap_grayerr_clr: got %0b want 0", bus.grayErr); end
    @(negedge clk);
    bus.localBinPtr = 4'd8;
    #1;
    total++; if (bus.level !== 4'd0) begin bad++; $display("FAIL wrap_level_local8: got %0h want 0", bus.level); end
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL wrap_empty_local8: got %0b want 1", bus.empty); end
    @(negedge clk);
    bus.localBinPtr = 4'd0;
    bus.grayPtrIn   = 4'b1101;
    settle(LAT + 1);
    total++; if (bus.level !== 4'd9) begin bad++; $display("FAIL wrap_level9: got %0h want 9", bus.level); end
    total++; if (bus.levelErr !== 1'b1) begin bad++; $display("FAIL wrap_levelerr9: got %0b want 1", bus.levelErr); end
    @(negedge clk);
    bus.grayPtrIn = 4'b1100;
    settle(LAT + 4);
    total++; if (bus.level !== 4'd8) begin bad++; $display("FAIL wrap_level_back8: got %0h want 8", bus.level); end
    total++; if (bus.levelErr !== 1'b1) begin bad++; $display("FAIL wrap_levelerr_sticky: got %0b want 1", bus.levelErr); end
    pulse_clear();
    total++; if (bus.levelErr !== 1'b0) begin bad++; $display("FAIL wrap_levelerr_clr: got %0b want 0", bus.levelErr); end
  endtask

  task automatic test_gray_violation();
    @(negedge clk);
    bus.grayPtrIn = 4'b0000;
    settle(LAT + 1);
    pulse_clear();
    total++; if (bus.grayErr !== 1'b0) begin bad++; $display("FAIL viol_pre_clr: got %0b want 0", bus.grayErr); end
    @(negedge clk);
    bus.grayPtrIn = 4'b0011;
    settle(2);
    total++; if (bus.grayErr !== 1'b0) begin bad++; $display("FAIL viol_early: got %0b want 0", bus.grayErr); end
    @(negedge clk);
    total++; if (bus.grayErr !== 1'b1) begin bad++; $display("FAIL viol_set: got %0b want 1", bus.grayErr); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++; if (bus.grayErr !== 1'b1) begin bad++; $display("FAIL viol_hold[%0d]: got %0b want 1", i, bus.grayErr); end
    end
    total++; if (bus.binPtrOut !== 4'd2) begin bad++; $display("FAIL viol_bin: got %0h want 2", bus.binPtrOut); end
    bus.errClr = 1'b1;
    @(negedge clk);
    bus.errClr = 1'b0;
    total++; if (bus.grayErr !== 1'b0) begin bad++; $display("FAIL viol_clr: got %0b want 0", bus.grayErr); end
  endtask

  task automatic test_mid_reset();
    int first_k;
    int adv_cnt;
    @(negedge clk);
    bus.grayPtrIn = 4'b0111;
    settle(LAT + 1);
    total++; if (bus.binPtrOut !== 4'd5) begin bad++; $display("FAIL mrst_bin5: got %0h want 5", bus.binPtrOut); end
    @(posedge clk);
    #2 rstN = 1'b0;
    #1;
    total++; if (bus.binPtrOut !== 4'd0) begin bad++; $display("FAIL mrst_bin: got %0h want 0", bus.binPtrOut); end
    total++; if (bus.ptrAdvance !== 1'b0) begin bad++; $display("FAIL mrst_adv: got %0b want 0", bus.ptrAdvance); end
    total++; if (bus.level !== 4'd0) begin bad++; $display("FAIL mrst_level: got %0h want 0", bus.level); end
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL mrst_empty: got %0b want 1", bus.empty); end
    @(negedge clk);
    rstN = 1'b1;
    first_k = -1;
    adv_cnt = 0;
    for (int k = 1; k <= LAT + 3; k++) begin
      @(negedge clk);
      if (bus.binPtrOut === 4'd5 && first_k < 0) first_k = k;
      if (bus.ptrAdvance === 1'b1) adv_cnt++;
    end
    total++; if (first_k !== LAT) begin bad++; $display("FAIL mrst_latency: got %0d want %0d", first_k, LAT); end
    total++; if (adv_cnt !== 1) begin bad++; $display("FAIL mrst_adv_count: got %0d want 1", adv_cnt); end
  endtask

  task automatic test_random_stream();
    logic [N-1:0] cur_bin;
    logic [N-1:0] cur_gray;
    logic [N-1:0] g;
    logic [N-1:0] loc;
    logic [N:0]   e;
    pulse_clear();
    cur_bin  = 4'd5;
    cur_gray = bus.grayPtrIn;
    exp_q.delete();
    for (int c = 0; c < 40 + LAT + 1; c++) begin
      @(negedge clk);
      if (c < 40) cur_bin = cur_bin + 4'($urandom_range(0, 1));
      g   = bin2gray(cur_bin);
      loc = 4'($urandom_range(0, 15));
      bus.grayPtrIn   = g;
      bus.localBinPtr = loc;
      exp_q.push_back({(g != cur_gray), model_bin(g)});
      cur_gray = g;
      #1;
      if (exp_q.size() == LAT + 1) begin
        e = exp_q.pop_front();
        total++; if (bus.binPtrOut !== e[N-1:0]) begin bad++; $display("FAIL rnd_bin[%0d]: got %0h want %0h", c, bus.binPtrOut, e[N-1:0]); end
        total++; if (bus.ptrAdvance !== e[N]) begin bad++; $display("FAIL rnd_adv[%0d]: got %0b want %0b", c, bus.ptrAdvance, e[N]); end
        total++; if (bus.level !== 4'(e[N-1:0] - loc)) begin bad++; $display("FAIL rnd_level[%0d]: got %0h want %0h", c, bus.level, 4'(e[N-1:0] - loc)); end
        total++; if (bus.empty !== (e[N-1:0] == loc)) begin bad++; $display("FAIL rnd_empty[%0d]: got %0b want %0b", c, bus.empty, (e[N-1:0] == loc)); end
      end
    end
    total++; if (bus.grayErr !== 1'b0) begin bad++; $display("FAIL rnd_grayerr: got %0b want 0", bus.grayErr); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_gray_walk();
    test_level_wrap();
    test_gray_violation();
    test_mid_reset();
    test_random_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
